// File: rtl/ikaopll_acc_mixer.sv
// Sample accumulator/mixer: sums signed melody and rhythm DAC slot products over one
// frame and emits a saturated 16-bit sample at each frame boundary.
//
// state | meaning
// IDLE  | waiting for the first delayed frame marker; accumulator and counter held at 0
// RUN   | accumulating slots; frame ends on a delayed marker or a full frame without one
module ikaopll_acc_mixer #(
   parameter int FRAME_LEN = 18,
   parameter int CYC0_DLY  = 3
) (
   input  logic        i_EMUCLK,
   input  logic        i_RST_n,
   input  logic        i_phi1_NCEN_n,
   input  logic        i_CYCLE_00,
   input  logic        i_DAC_EN_MO,
   input  logic        i_DAC_EN_RO,
   input  logic        i_SND_SIGN,
   input  logic [7:0]  i_SND_MAG,
   input  logic [4:0]  i_MOVOL,
   input  logic [4:0]  i_ROVOL,
   output logic [15:0] o_SAMPLE,
   output logic        o_SAMPLE_STRB,
   output logic        o_CLIP,
   output logic        o_SYNC_LOST
);

   localparam int CW = $clog2(FRAME_LEN + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic                 tick;
   logic [CYC0_DLY-1:0]  dly_q;
   logic                 cyc0_d;
   logic signed [8:0]    snd_val;
   logic signed [13:0]   snd_ext, mo_gain, ro_gain, mo_prod, ro_prod;
   logic signed [19:0]   contrib, acc_q, acc_d, acc_add;
   logic signed [20:0]   acc_wide;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 sat_hi, sat_lo, frame_end, lost_d;
   logic [15:0]          sample_sat;

   assign tick    = ~i_phi1_NCEN_n;
   assign cyc0_d  = dly_q[CYC0_DLY-1];

   // Negative samples are one's-complement style: sign 1, magnitude 0 is -1.
   assign snd_val = i_SND_SIGN ? {1'b1, ~i_SND_MAG} : {1'b0, i_SND_MAG};
   assign snd_ext = 14'(snd_val);
   assign mo_gain = 14'($signed(i_MOVOL));
   assign ro_gain = 14'($signed(i_ROVOL));
   assign mo_prod = i_DAC_EN_MO ? snd_ext * mo_gain : '0;
   assign ro_prod = i_DAC_EN_RO ? snd_ext * ro_gain : '0;
   assign contrib = 20'(mo_prod) + 20'(ro_prod);

   // Clamp rather than wrap so a long frame can never fold a large sum back around.
   assign acc_wide = 21'(acc_q) + 21'(contrib);
   assign acc_add  = (acc_wide > 21'sd524287)  ? 20'sh7FFFF :
                     (acc_wide < -21'sd524288) ? 20'sh80000 : acc_wide[19:0];

   assign sat_hi     = acc_q > 20'sd32767;
   assign sat_lo     = acc_q < -20'sd32768;
   assign sample_sat = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : acc_q[15:0]);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      lost_d    = o_SYNC_LOST;
      frame_end = 1'b0;
      case (state_q)
         IDLE: begin
            acc_d = '0;
            cnt_d = '0;
            if (cyc0_d) begin
               state_d = RUN;
               acc_d   = contrib;
               cnt_d   = CW'(1);
            end
         end
         RUN: begin
            // cnt_q == FRAME_LEN marks the tick where an aligned marker is due.
            if (cyc0_d || (cnt_q == CW'(FRAME_LEN))) begin
               frame_end = 1'b1;
               acc_d     = contrib;
               cnt_d     = CW'(1);
               if (!cyc0_d)
                  lost_d = 1'b1;
               else if (cnt_q == CW'(FRAME_LEN))
                  lost_d = 1'b0;
            end else begin
               acc_d = acc_add;
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_EMUCLK) begin
      if (!i_RST_n) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         cnt_q         <= '0;
         dly_q         <= '0;
         o_SAMPLE      <= '0;
         o_SAMPLE_STRB <= 1'b0;
         o_CLIP        <= 1'b0;
         o_SYNC_LOST   <= 1'b0;
      end else if (tick) begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         dly_q[0] <= i_CYCLE_00;
         for (int i = 1; i < CYC0_DLY; i++)
            dly_q[i] <= dly_q[i-1];
         o_SAMPLE_STRB <= frame_end;
         o_SYNC_LOST   <= lost_d;
         if (frame_end) begin
            o_SAMPLE <= sample_sat;
            o_CLIP   <= sat_hi | sat_lo;
         end
      end
   end

endmodule

// File: tb/tb_ikaopll_acc_mixer.sv
// Bench for ikaopll_acc_mixer: frame vector table, hand-written sync/reset/stall
// sequences and random traffic, all compared against a tick-level reference model.
module tb_ikaopll_acc_mixer;

   localparam int FRAME_LEN = 18;
   localparam int CYC0_DLY  = 3;

   logic        clk = 1'b0;
   logic        rst_n, ncen, cyc00, en_mo, en_ro, sign;
   logic [7:0]  mag;
   logic [4:0]  movol, rovol;
   logic [15:0] o_sample;
   logic        o_strb, o_clip, o_lost;

   always #5 clk = ~clk;

   ikaopll_acc_mixer #(.FRAME_LEN(FRAME_LEN), .CYC0_DLY(CYC0_DLY)) dut (
      .i_EMUCLK      (clk),
      .i_RST_n       (rst_n),
      .i_phi1_NCEN_n (ncen),
      .i_CYCLE_00    (cyc00),
      .i_DAC_EN_MO   (en_mo),
      .i_DAC_EN_RO   (en_ro),
      .i_SND_SIGN    (sign),
      .i_SND_MAG     (mag),
      .i_MOVOL       (movol),
      .i_ROVOL       (rovol),
      .o_SAMPLE      (o_sample),
      .o_SAMPLE_STRB (o_strb),
      .o_CLIP        (o_clip),
      .o_SYNC_LOST   (o_lost)
   );

   typedef struct {
      bit         mo;
      bit         ro;
      bit         s;
      logic [7:0] mag;
      logic [4:0] mv;
      logic [4:0] rv;
      int         nslots;
      int         exp_sample;
      bit         exp_clip;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // Reference model state: marker history (newest first), frame progress, running sum.
   bit m_hist[$];
   bit m_run;
   int m_pos, m_sum, e_sample;
   bit e_strb, e_clip, e_lost;
   int tick_no = 0, last_strb_tick = 0, last_gap = 0;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int gain(logic [4:0] g);
      return int'($signed(g));
   endfunction

   function automatic int snd_value(bit s, logic [7:0] m);
      return s ? -(int'(m) + 1) : int'(m);
   endfunction

   task automatic model_step();
      bit cd;
      int c;
      if (!rst_n) begin
         m_hist.delete();
         m_run = 0; m_pos = 0; m_sum = 0;
         e_sample = 0; e_strb = 0; e_clip = 0; e_lost = 0;
         return;
      end
      if (ncen) return;
      cd = (m_hist.size() >= CYC0_DLY) ? m_hist[CYC0_DLY-1] : 1'b0;
      c  = (en_mo ? snd_value(sign, mag) * gain(movol) : 0) +
           (en_ro ? snd_value(sign, mag) * gain(rovol) : 0);
      e_strb = 0;
      if (!m_run) begin
         if (cd) begin m_run = 1; m_sum = c; m_pos = 1; end
      end else if (cd || m_pos == FRAME_LEN) begin
         e_strb   = 1;
         e_clip   = (m_sum > 32767) || (m_sum < -32768);
         e_sample = (m_sum > 32767) ? 32767 : ((m_sum < -32768) ? -32768 : m_sum);
         if (!cd) e_lost = 1;
         else if (m_pos == FRAME_LEN) e_lost = 0;
         m_sum = c;
         m_pos = 1;
      end else begin
         m_sum += c;
         m_pos++;
      end
      m_hist.push_front(cyc00);
      if (m_hist.size() > 8) void'(m_hist.pop_back());
   endtask

   task automatic cycle();
      bit ticked;
      ticked = rst_n && !ncen;
      @(posedge clk);
      model_step();
      #1;
      check("model_strb",   int'(o_strb), int'(e_strb));
      check("model_sample", int'($signed(o_sample)), e_sample);
      check("model_clip",   int'(o_clip), int'(e_clip));
      check("model_lost",   int'(o_lost), int'(e_lost));
      if (ticked) begin
         tick_no++;
         if (o_strb) begin
            last_gap       = tick_no - last_strb_tick;
            last_strb_tick = tick_no;
         end
      end
   endtask

   task automatic drive_tick(bit cyc, vec_t v, bit en);
      cyc00 = cyc;
      en_mo = v.mo & en;
      en_ro = v.ro & en;
      sign  = v.s;
      mag   = v.mag;
      movol = v.mv;
      rovol = v.rv;
      ncen  = 1'b0;
      cycle();
   endtask

   // mode 0: no checks, 1: strobe expected at slot 0, 2: no strobe at slot 0
   task automatic run_frame(vec_t v, bit marker, int mode, int exp_gap, bit exp_lost,
                            int exp_sample, bit exp_clip, bit stall);
      for (int i = 0; i < FRAME_LEN; i++) begin
         drive_tick(marker && (i == FRAME_LEN - CYC0_DLY), v, i < v.nslots);
         if (i == 0) begin
            if (mode == 1) begin
               check("frame_strb",   int'(o_strb), 1);
               check("frame_sample", int'($signed(o_sample)), exp_sample);
               check("frame_clip",   int'(o_clip), int'(exp_clip));
               check("frame_lost",   int'(o_lost), int'(exp_lost));
               if (exp_gap > 0) check("frame_gap", last_gap, exp_gap);
            end else if (mode == 2) begin
               check("frame_nostrb", int'(o_strb), 0);
            end
            if (stall) begin
               for (int k = 0; k < 5; k++) begin
                  ncen  = 1'b1;
                  cyc00 = 1'($urandom_range(0, 1));
                  en_mo = 1'($urandom_range(0, 1));
                  en_ro = 1'($urandom_range(0, 1));
                  mag   = 8'($urandom);
                  cycle();
                  check("stall_strb", int'(o_strb), 1);
               end
            end
         end
      end
   endtask

   vec_t tab[9];
   vec_t zv, v7, v50, vbig, vpost;

   initial begin
      tab[0] = '{1, 0, 0, 8'd100, 5'd4,      5'd0,      1,  400,    0};
      tab[1] = '{0, 1, 1, 8'd0,   5'd0,      5'd1,      1,  -1,     0};
      tab[2] = '{1, 1, 1, 8'd255, 5'b10000,  5'b10000,  18, 32767,  1};
      tab[3] = '{0, 0, 0, 8'd0,   5'd0,      5'd0,      0,  0,      0};
      tab[4] = '{1, 1, 0, 8'd255, 5'b10000,  5'b10000,  18, -32768, 1};
      tab[5] = '{1, 0, 1, 8'd10,  5'd3,      5'd0,      5,  -165,   0};
      tab[6] = '{1, 0, 0, 8'd128, 5'b10000,  5'd0,      16, -32768, 0};
      tab[7] = '{1, 0, 1, 8'd127, 5'b10000,  5'd0,      16, 32767,  1};
      tab[8] = '{0, 0, 0, 8'd0,   5'd0,      5'd0,      0,  0,      0};
      zv     = '{0, 0, 0, 8'd0,   5'd0,      5'd0,      0,  0,      0};
      v7     = '{1, 0, 0, 8'd7,   5'd2,      5'd0,      1,  14,     0};
      v50    = '{1, 0, 0, 8'd50,  5'd2,      5'd0,      1,  100,    0};
      vbig   = '{1, 1, 0, 8'd255, 5'd15,     5'd15,     18, 0,      0};
      vpost  = '{1, 0, 1, 8'd3,   5'd5,      5'd0,      1,  -20,    0};

      rst_n = 1'b0; ncen = 1'b1; cyc00 = 1'b0; en_mo = 1'b0; en_ro = 1'b0;
      sign = 1'b0; mag = '0; movol = '0; rovol = '0;
      repeat (3) cycle();
      check("reset_sample", int'(o_sample), 0);
      check("reset_strb",   int'(o_strb), 0);
      check("reset_lost",   int'(o_lost), 0);
      rst_n = 1'b1;

      // Prologue frame carries the first marker; the table frames follow aligned.
      run_frame(zv, 1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k <= 9; k++) begin
         vec_t cur;
         int   ps;
         bit   pc;
         cur = (k < 9) ? tab[k] : zv;
         ps  = (k > 0) ? tab[(k > 0) ? k - 1 : 0].exp_sample : 0;
         pc  = (k > 0) ? tab[(k > 0) ? k - 1 : 0].exp_clip : 1'b0;
         run_frame(cur, 1, (k > 0) ? 1 : 2, (k > 1) ? FRAME_LEN : -1, 0, ps, pc, 0);
      end

      // Missing marker: forced end 18 ticks later, sticky flag, then cleared.
      run_frame(zv, 0, 1, FRAME_LEN, 0, 0, 0, 0);
      run_frame(zv, 1, 1, FRAME_LEN, 1, 0, 0, 0);
      run_frame(zv, 1, 1, FRAME_LEN, 0, 0, 0, 0);

      // Markers every 12 ticks give 12-tick frames without a sync-lost flag.
      for (int j = 0; j < 48; j++) begin
         drive_tick((j % 12) == 9, v7, (j % 12) == 0);
         if (j == 0) begin
            check("p12_first_gap", last_gap, FRAME_LEN);
            check("p12_first_smp", int'($signed(o_sample)), 0);
         end else if ((j % 12) == 0) begin
            check("p12_strb",   int'(o_strb), 1);
            check("p12_gap",    last_gap, 12);
            check("p12_sample", int'($signed(o_sample)), 14);
            check("p12_lost",   int'(o_lost), 0);
         end
      end
      run_frame(zv, 1, 1, 12, 0, 14, 0, 0);

      // Tick enable held off right after a strobe: strobe stays up, nothing advances.
      run_frame(zv, 1, 1, FRAME_LEN, 0, 0, 0, 1);
      run_frame(v50, 1, 1, FRAME_LEN, 0, 0, 0, 0);

      // Reset mid-frame discards the partial sum and needs two markers to strobe.
      for (int i = 0; i < 6; i++) drive_tick(1'b0, vbig, 1'b1);
      check("pre_reset_sample", int'($signed(o_sample)), 100);
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cycle();
         check("rst_sample", int'(o_sample), 0);
         check("rst_strb",   int'(o_strb), 0);
         check("rst_clip",   int'(o_clip), 0);
         check("rst_lost",   int'(o_lost), 0);
      end
      rst_n = 1'b1;
      for (int i = 6; i < FRAME_LEN; i++) drive_tick(i == FRAME_LEN - CYC0_DLY, vbig, 1'b1);
      run_frame(vpost, 1, 2, 0, 0, 0, 0, 0);
      run_frame(zv, 1, 1, -1, 0, -20, 0, 0);

      // Random traffic: arbitrary markers, stalls, gains and occasional resets.
      for (int n = 0; n < 800; n++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         ncen  = ($urandom_range(0, 5) == 0);
         cyc00 = ($urandom_range(0, 15) == 0);
         en_mo = 1'($urandom_range(0, 1));
         en_ro = 1'($urandom_range(0, 1));
         sign  = 1'($urandom_range(0, 1));
         mag   = 8'($urandom);
         movol = 5'($urandom);
         rovol = 5'($urandom);
         cycle();
      end
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
